// File: rtl/cee_burst_sequencer.sv
// Burst controller for the channel estimator/equalizer: clears it, streams CE and data
// symbols in, waits for the equalized buffer, then drains it through a small output FIFO.
//   state | meaning
//   CLEAR | hold cee_tx_done for CLR_CYCLES cycles
//   IDLE  | ready for word 0 of the next burst
//   LOAD  | write CE (gap-free) and data (gaps allowed) words
//   WAIT  | wait for cee_out_full, bounded by TIMEOUT cycles
//   READ  | issue read pointers and stream OUT_N equalized words
module cee_burst_sequencer #(
  parameter int ACTIVE_SUBCARR = 28,
  parameter int CEST_NUM       = 4,
  parameter int SYMBOL_NUM     = 8,
  parameter int READ_LAT       = 3,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT        = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_din,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] cee_din,
  output logic        cee_wren,
  output logic        cee_tx_done,
  output logic [7:0]  cee_read_ptr,
  input  logic [15:0] cee_dout,
  input  logic        cee_out_full,
  output logic [15:0] m_dout,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        err
);

  localparam logic [8:0] LOAD_N     = 9'((CEST_NUM + SYMBOL_NUM) * ACTIVE_SUBCARR);
  localparam logic [8:0] LOAD_LAST  = 9'((CEST_NUM + SYMBOL_NUM) * ACTIVE_SUBCARR - 1);
  localparam logic [8:0] CE_N       = 9'(CEST_NUM * ACTIVE_SUBCARR);
  localparam logic [7:0] OUT_LAST   = 8'(SYMBOL_NUM * ACTIVE_SUBCARR - 1);
  localparam logic [9:0] WAIT_INIT  = 10'(TIMEOUT - 1);
  localparam logic [3:0] CLR_INIT   = 4'(CLR_CYCLES - 1);
  localparam int         FIFO_DEPTH = READ_LAT + 1;
  localparam int         PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [PW+1:0] OCC_MAX  = (PW+2)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_READ
  } state_t;

  state_t state_q, state_d;

  logic [3:0]          clr_cnt_q;
  logic [8:0]          load_cnt_q;
  logic [9:0]          wait_cnt_q;
  logic [7:0]          read_ptr_q;
  logic                issue_done_q;
  logic [7:0]          out_cnt_q;
  logic [READ_LAT-1:0] inflight_q;
  logic [15:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_q, rd_q;
  logic [PW:0]         fifo_cnt_q;

  logic          accept, pop, push, issue, err_set;
  logic [PW:0]   inflight_cnt;
  logic [PW+1:0] occ_after_pop;

  assign accept       = s_valid & s_ready;
  assign m_valid      = (fifo_cnt_q != '0);
  assign m_dout       = fifo_mem[rd_q];
  assign m_last       = m_valid && (out_cnt_q == OUT_LAST);
  assign pop          = m_valid & m_ready;
  assign push         = inflight_q[READ_LAT-1];
  assign busy         = (state_q != ST_IDLE);
  assign cee_tx_done  = (state_q == ST_CLEAR);
  assign cee_read_ptr = read_ptr_q;

  // The word leaving this cycle frees its slot, so a full pipe can still issue
  // while the consumer pops; that is what sustains one word per cycle.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LAT; i++)
      inflight_cnt = inflight_cnt + (PW+1)'(inflight_q[i]);
    occ_after_pop = (PW+2)'(fifo_cnt_q) + (PW+2)'(inflight_cnt) - (PW+2)'(pop);
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    issue   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_CLEAR: if (clr_cnt_q == '0) state_d = ST_IDLE;
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (!s_valid && load_cnt_q < CE_N) begin
          err_set = 1'b1;
          state_d = ST_CLEAR;
        end else if (s_valid && load_cnt_q == LOAD_LAST) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cee_out_full) begin
          state_d = ST_READ;
        end else if (wait_cnt_q == '0) begin
          err_set = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_READ: begin
        issue = !issue_done_q && (occ_after_pop < OCC_MAX);
        if (pop && out_cnt_q == OUT_LAST) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_q] <= cee_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= CLR_INIT;
      load_cnt_q   <= '0;
      wait_cnt_q   <= WAIT_INIT;
      read_ptr_q   <= '0;
      issue_done_q <= 1'b0;
      out_cnt_q    <= '0;
      inflight_q   <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      fifo_cnt_q   <= '0;
      cee_wren     <= 1'b0;
      cee_din      <= '0;
      err          <= 1'b0;
    end else begin
      state_q  <= state_d;
      err      <= err_set;
      cee_wren <= accept;
      if (accept) cee_din <= s_din;

      if (state_d == ST_CLEAR && state_q != ST_CLEAR) clr_cnt_q <= CLR_INIT;
      else if (state_q == ST_CLEAR && clr_cnt_q != '0) clr_cnt_q <= clr_cnt_q - 4'd1;

      if (state_q == ST_CLEAR) load_cnt_q <= '0;
      else if (accept && load_cnt_q != LOAD_N) load_cnt_q <= load_cnt_q + 9'd1;

      if (state_q != ST_WAIT) wait_cnt_q <= WAIT_INIT;
      else if (wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - 10'd1;

      if (state_q != ST_READ) begin
        read_ptr_q   <= '0;
        issue_done_q <= 1'b0;
        out_cnt_q    <= '0;
        inflight_q   <= '0;
        wr_q         <= '0;
        rd_q         <= '0;
        fifo_cnt_q   <= '0;
      end else begin
        inflight_q <= {inflight_q[READ_LAT-2:0], issue};
        if (issue) begin
          if (read_ptr_q == OUT_LAST) issue_done_q <= 1'b1;
          else read_ptr_q <= read_ptr_q + 8'd1;
        end
        if (push) wr_q <= (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
        if (pop) begin
          rd_q      <= (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
          out_cnt_q <= out_cnt_q + 8'd1;
        end
        if (push && !pop) fifo_cnt_q <= fifo_cnt_q + (PW+1)'(1);
        else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - (PW+1)'(1);
      end
    end
  end

endmodule
